// File: rtl/kanade32_mmio_pkg.sv
// Shared definitions for the kanade32 MMIO peripherals: UART register offsets,
// STATUS bit positions and the transmitter state encoding.
package kanade32_mmio_pkg;

  localparam logic [31:0] UART_BASE = 32'hFFFF_0000;

  localparam logic [1:0] UART_OFS_TXDATA = 2'd0;
  localparam logic [1:0] UART_OFS_STATUS = 2'd1;
  localparam logic [1:0] UART_OFS_DIV    = 2'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_IE    = 4;
  localparam int ST_CNT   = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Divider values below 2 still give one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with extra-MSB pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [AW:0]  wptr_q, rptr_q;
  logic [W-1:0] mem_q [0:(1<<AW)-1];
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data bus, one-cycle read latency.
// Define KANADE32_UART_IRQ_EN to build the IE bit and the irq output.
module mmio_uart_tx
  import kanade32_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = UART_BASE,
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byteen_i,
  input  logic        wren_i,
  input  logic        rden_i,
  output logic        sel_o,
  output logic [31:0] rdata_o,
  output logic        txd_o,
  output logic        irq_o
);

  logic [1:0]       ofs;
  logic             wr_hit, rd_hit, wr_tx, wr_st, wr_div;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] fifo_cnt;

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] tmr_q, tmr_d, cur_div_q, cur_div_d, div_q;
  logic        txd_q, txd_d, ovf_q, busy, bit_end, load, ie;
  logic [31:0] status_w, rdata_d, rdata_q;
  logic        unused_bits;

  assign sel_o  = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign ofs    = addr_i[3:2];
  assign wr_hit = wren_i & sel_o;
  assign rd_hit = rden_i & sel_o;
  assign wr_tx  = wr_hit && (ofs == UART_OFS_TXDATA) && byteen_i[0];
  assign wr_st  = wr_hit && (ofs == UART_OFS_STATUS) && byteen_i[0];
  assign wr_div = wr_hit && (ofs == UART_OFS_DIV) && (byteen_i[1:0] == 2'b11);

  assign unused_bits = ^{addr_i[1:0], wdata_i[31:16], byteen_i[3:2]};

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (wr_tx),
    .din_i   (wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign busy    = (state_q != UART_IDLE);
  assign bit_end = (tmr_q == 16'd0);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    tmr_d     = tmr_q;
    cur_div_d = cur_div_q;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    if (state_q != UART_IDLE) tmr_d = bit_end ? cur_div_q - 16'd1 : tmr_q - 16'd1;
    case (state_q)
      UART_IDLE:  if (!fifo_empty) load = 1'b1;
      UART_START: if (bit_end) begin
        state_d = UART_DATA;
        bit_d   = 3'd0;
      end
      UART_DATA:  if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = UART_STOP;
      end
      UART_STOP:  if (bit_end) begin
        if (!fifo_empty) load = 1'b1;
        else state_d = UART_IDLE;
      end
      default:    state_d = UART_IDLE;
    endcase
    // Stop-to-start reload keeps back-to-back frames gapless.
    if (load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_dout;
      cur_div_d = eff_div(div_q);
      tmr_d     = eff_div(div_q) - 16'd1;
      state_d   = UART_START;
    end
    txd_d = (state_d == UART_START) ? 1'b0 :
            (state_d == UART_DATA)  ? shift_d[0] : 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= UART_IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      tmr_q     <= '0;
      cur_div_q <= 16'd1;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      tmr_q     <= tmr_d;
      cur_div_q <= cur_div_d;
      txd_q     <= txd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
      div_q <= DEFAULT_DIV;
    end else begin
      if (wr_tx && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      else if (wr_st && wdata_i[ST_OVF])   ovf_q <= 1'b0;
      if (wr_div) div_q <= wdata_i[15:0];
    end
  end

`ifdef KANADE32_UART_IRQ_EN
  logic ie_q, irq_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_st) ie_q <= wdata_i[ST_IE];
      irq_q <= ie_q & ((fifo_empty & ~busy) | ovf_q);
    end
  end
  assign ie    = ie_q;
  assign irq_o = irq_q;
`else
  assign ie    = 1'b0;
  assign irq_o = 1'b0;
`endif

  always_comb begin
    status_w                        = '0;
    status_w[ST_FULL]               = fifo_full;
    status_w[ST_EMPTY]              = fifo_empty;
    status_w[ST_BUSY]               = busy;
    status_w[ST_OVF]                = ovf_q;
    status_w[ST_IE]                 = ie;
    status_w[ST_CNT +: FIFO_AW + 1] = fifo_cnt;
    rdata_d = '0;
    if (rd_hit) begin
      case (ofs)
        UART_OFS_STATUS: rdata_d = status_w;
        UART_OFS_DIV:    rdata_d = {16'd0, div_q};
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
  assign txd_o   = txd_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected reads and frames,
// independent monitors check rdata and every cycle of each txd frame.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_DV = BASE + 32'd8;
  localparam logic [31:0] A_RS = BASE + 32'd12;

  logic        clk_i = 1'b0, reset_i = 1'b1;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [3:0]  byteen_i = '0;
  logic        wren_i = 1'b0, rden_i = 1'b0;
  logic        sel_o, txd_o, irq_o;
  logic [31:0] rdata_o;

  mmio_uart_tx dut (
    .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .byteen_i(byteen_i), .wren_i(wren_i), .rden_i(rden_i), .sel_o(sel_o),
    .rdata_o(rdata_o), .txd_o(txd_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         contig;
  } frame_t;

  frame_t      txq[$];
  logic [31:0] rq[$];
  int          vectors = 0, miscompares = 0;

`ifdef KANADE32_UART_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  // rdata monitor: a load seen at a posedge is checked at the following negedge
  logic rd_seen = 1'b0;
  always @(posedge clk_i) rd_seen <= rden_i;
  always @(negedge clk_i) begin
    if (rd_seen) begin
      vectors++;
      if (rq.size() == 0) begin
        miscompares++;
        $display("FAIL rdata_unexpected: got %h with no queued expectation", rdata_o);
      end else begin
        logic [31:0] e;
        e = rq.pop_front();
        if (rdata_o !== e) begin
          miscompares++;
          $display("FAIL rdata: got %h want %h", rdata_o, e);
        end
      end
    end
  end

  // txd monitor: each frame is compared cycle by cycle over 10*div cycles
  bit         on = 1'b0;
  int         cyc = 0, gap = 1, bad = 0, first_bad = -1;
  frame_t     cur;
  always @(negedge clk_i) begin
    if (reset_i) begin
      on  = 1'b0;
      gap = 1;
    end else begin
      if (!on && txd_o === 1'b0) begin
        if (txq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL frame_unexpected: start bit at %0t with no queued frame", $time);
        end else begin
          cur = txq.pop_front();
          on = 1'b1; cyc = 0; bad = 0; first_bad = -1;
          if (cur.contig) begin
            vectors++;
            if (gap != 0) begin
              miscompares++;
              $display("FAIL frame_gap: got %0d idle cycles before byte %h want 0", gap, cur.data);
            end
          end
        end
      end
      if (on) begin
        int b; logic expb; logic [7:0] d;
        d = cur.data;
        b = cyc / cur.div;
        if (b == 0)      expb = 1'b0;
        else if (b == 9) expb = 1'b1;
        else             expb = d[b-1];
        if (txd_o !== expb) begin
          bad++;
          if (first_bad < 0) first_bad = cyc;
        end
        cyc++;
        if (cyc == 10 * cur.div) begin
          vectors++;
          if (bad != 0) begin
            miscompares++;
            $display("FAIL frame_bits: byte %h div %0d got %0d wrong cycles (first at %0d) want 0",
                     cur.data, cur.div, bad, first_bad);
          end
          on = 1'b0; gap = 0;
        end
      end else begin
        gap++;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr_i = a; wdata_i = d; byteen_i = be; wren_i = 1'b1;
    @(negedge clk_i);
    wren_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    addr_i = a; rden_i = 1'b1;
    rq.push_back(e);
    @(negedge clk_i);
    rden_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    idle(3);
    reset_i = 1'b0;
    chk("txd_reset", {31'd0, txd_o}, 32'd1);
    chk("irq_reset", {31'd0, irq_o}, 32'd0);
    rd(A_ST, 32'h0000_0002);
    rd(A_DV, 32'd434);
    rd(A_TX, 32'd0);

    // single frame at DIV=4; partial DIV write ignored
    wr(A_DV, 32'd4, 4'hF);
    wr(A_DV, 32'd7, 4'b0001);
    rd(A_DV, 32'd4);
    txq.push_back('{8'hA5, 4, 1'b0});
    wr(A_TX, 32'h0000_00A5, 4'b0001);
    rd(A_ST, 32'h0000_0100);
    rd(A_ST, 32'h0000_0006);
    idle(45);
    rd(A_ST, 32'h0000_0002);

    // three back-to-back frames at DIV=2
    wr(A_DV, 32'd2, 4'hF);
    txq.push_back('{8'h01, 2, 1'b0});
    txq.push_back('{8'h02, 2, 1'b1});
    txq.push_back('{8'h03, 2, 1'b1});
    wr(A_TX, 32'h01, 4'b0001);
    wr(A_TX, 32'h02, 4'b0001);
    wr(A_TX, 32'h03, 4'b0001);
    rd(A_ST, 32'h0000_0204);
    idle(65);
    rd(A_ST, 32'h0000_0002);

    // address decode: outside window and reserved offset
    addr_i = 32'h1000_0000; #1;
    chk("sel_outside", {31'd0, sel_o}, 32'd0);
    addr_i = 32'hFFFF_0010; #1;
    chk("sel_above", {31'd0, sel_o}, 32'd0);
    addr_i = A_ST; #1;
    chk("sel_inside", {31'd0, sel_o}, 32'd1);
    wr(32'h1000_0000, 32'h55, 4'hF);
    wr(32'h1000_0008, 32'h9, 4'hF);
    wr(A_RS, 32'hFFFF_FFFF, 4'hF);
    rd(A_RS, 32'd0);
    rd(32'h1000_0004, 32'd0);
    rd(A_ST, 32'h0000_0002);
    rd(A_DV, 32'd2);

    // fill to full, overflow, clear
    wr(A_DV, 32'd1000, 4'hF);
    txq.push_back('{8'h10, 1000, 1'b0});
    for (int i = 0; i < 17; i++) wr(A_TX, 32'h10 + 32'(i), 4'b0001);
    rd(A_ST, 32'h0000_1005);
    wr(A_TX, 32'hEE, 4'b0001);
    rd(A_ST, 32'h0000_100D);
    wr(A_ST, 32'h0000_0008, 4'hF);
    rd(A_ST, 32'h0000_1005);

    // reset while the first frame is in its data bits
    idle(1200);
    reset_i = 1'b1;
    txq.delete();
    @(negedge clk_i);
    chk("txd_midframe_reset", {31'd0, txd_o}, 32'd1);
    idle(1);
    reset_i = 1'b0;
    rd(A_ST, 32'h0000_0002);
    rd(A_DV, 32'd434);
    chk("irq_after_reset", {31'd0, irq_o}, 32'd0);

    // DIV=0 acts as one cycle per bit; IE and irq
    wr(A_DV, 32'd0, 4'hF);
    rd(A_DV, 32'd0);
    wr(A_ST, 32'h0000_0010, 4'hF);
    rd(A_ST, IRQ_ON ? 32'h0000_0012 : 32'h0000_0002);
    chk("irq_idle_ie", {31'd0, irq_o}, {31'd0, IRQ_ON});
    txq.push_back('{8'h3C, 1, 1'b0});
    wr(A_TX, 32'h3C, 4'b0001);
    idle(2);
    chk("irq_busy", {31'd0, irq_o}, 32'd0);
    idle(12);
    chk("irq_drained", {31'd0, irq_o}, {31'd0, IRQ_ON});

    for (int i = 0; i < 400 && (txq.size() != 0 || on); i++) @(negedge clk_i);
    chk("frames_drained", 32'(txq.size()) + {31'd0, on}, 32'd0);
    chk("reads_drained", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
